// File: rtl/fft_bram_pkg.sv
// Shared types, default parameters and helpers for the FFT BRAM ping-pong writer.
package fft_bram_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        WAIT_BANK = 2'd2
    } state_t;

    localparam int DEF_NUM_CH      = 8;
    localparam int DEF_SAMPLE_W    = 24;
    localparam int DEF_OUT_W       = 32;
    localparam int DEF_FRAME_BEATS = 64;

    // Never returns 0 so single-entry counters still get a 1-bit register.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [63:0] sign_ext(input logic [63:0] sample, input int sw, input int ow);
        logic [63:0] shl;
        logic [63:0] ext;
        shl = sample << (64 - sw);
        ext = $signed(shl) >>> (64 - sw);
        return ext & ((64'd1 << ow) - 64'd1);
    endfunction

endpackage

// File: rtl/fft_beat_skid.sv
// One-entry hold register in front of the slice serialiser, plus the tready logic.
module fft_beat_skid #(
    parameter int BEAT_W = 384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BEAT_W-1:0] din,
    input  logic              push,
    input  logic              pop,
    input  logic              wait_bank,
    output logic              ready,
    output logic              hold_full,
    output logic [BEAT_W-1:0] hold_data
);
    logic ready_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en  <= 1'b0;
            hold_full <= 1'b0;
            hold_data <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                hold_full <= 1'b1;
                hold_data <= din;
            end else if (pop) begin
                hold_full <= 1'b0;
            end
        end
    end

    // ready_en keeps tready low throughout reset and until the first edge after it.
    assign ready = ready_en && !hold_full && !wait_bank;

endmodule

// File: rtl/fft_bram_pingpong_ctrl.sv
// Serialises AXI-Stream beats of NUM_CH complex samples into two BRAM banks
// used ping-pong, with the consumer freeing each bank via bank_release.
//   state     | meaning
//   IDLE      | shift register empty, waiting for a beat
//   WRITE     | writing one slice per cycle from the shift register
//   WAIT_BANK | current bank full, other bank still owned by the consumer
module fft_bram_pingpong_ctrl
    import fft_bram_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int OUT_W       = DEF_OUT_W,
    parameter int FRAME_BEATS = DEF_FRAME_BEATS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*2*SAMPLE_W-1:0] s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    input  logic                         bank_release,
    output logic [31:0]                  bram_addr,
    output logic [OUT_W-1:0]             bram_din_re,
    output logic [OUT_W-1:0]             bram_din_im,
    output logic [3:0]                   bram_we,
    output logic                         bram_en,
    output logic                         bram_rst,
    output logic                         bank_sel,
    output logic                         frame_done,
    output logic                         err_tlast
);
    localparam int SLICE_W = 2 * SAMPLE_W;
    localparam int BEAT_W  = NUM_CH * SLICE_W;
    localparam int WORDS   = FRAME_BEATS * NUM_CH;
    localparam int SLC_W   = clog2(NUM_CH);
    localparam int WIDX_W  = clog2(WORDS);
    localparam int BCNT_W  = clog2(FRAME_BEATS);
    localparam logic [31:0] BANK_BYTES = 32'(WORDS * 4);

    state_t              state, state_nx;
    logic [BEAT_W-1:0]   sh_data;
    logic [BEAT_W-1:0]   hold_data;
    logic [SLC_W-1:0]    slice_cnt;
    logic [WIDX_W-1:0]   word_idx;
    logic [BCNT_W-1:0]   beat_cnt;
    logic [1:0]          busy;
    logic                rel_ptr;
    logic                hold_full;
    logic                accept, writing, last_slice, last_word;
    logic                rel_ok, other_free, resume;
    logic                direct, pop, push;
    logic [SLICE_W-1:0]  cur;

    fft_beat_skid #(.BEAT_W(BEAT_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .din       (s_axis_tdata),
        .push      (push),
        .pop       (pop),
        .wait_bank (state == WAIT_BANK),
        .ready     (s_axis_tready),
        .hold_full (hold_full),
        .hold_data (hold_data)
    );

    assign accept     = s_axis_tvalid && s_axis_tready;
    assign writing    = (state == WRITE);
    assign last_slice = writing && (slice_cnt == SLC_W'(NUM_CH - 1));
    assign last_word  = writing && (word_idx == WIDX_W'(WORDS - 1));
    // Banks are consumed in fill order, so rel_ptr always names the oldest busy bank.
    assign rel_ok     = bank_release && busy[rel_ptr];
    assign other_free = !busy[!bank_sel] || (rel_ok && (rel_ptr == !bank_sel));
    assign resume     = (state == WAIT_BANK) && rel_ok;
    assign push       = accept && !direct;

    always_comb begin
        state_nx = state;
        direct   = 1'b0;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    direct   = 1'b1;
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                if (last_slice) begin
                    if (last_word && !other_free) state_nx = WAIT_BANK;
                    else if (hold_full)           pop = 1'b1;
                    else if (accept)              direct = 1'b1;
                    else                          state_nx = IDLE;
                end
            end
            WAIT_BANK: begin
                if (rel_ok) begin
                    pop      = hold_full;
                    state_nx = hold_full ? WRITE : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_data    <= '0;
            slice_cnt  <= '0;
            word_idx   <= '0;
            beat_cnt   <= '0;
            bank_sel   <= 1'b0;
            busy       <= 2'b00;
            rel_ptr    <= 1'b0;
            frame_done <= 1'b0;
            err_tlast  <= 1'b0;
        end else begin
            if (direct || pop) begin
                sh_data   <= pop ? hold_data : s_axis_tdata;
                slice_cnt <= '0;
            end else if (writing) begin
                sh_data   <= sh_data >> SLICE_W;
                slice_cnt <= last_slice ? '0 : slice_cnt + 1'b1;
            end
            if (writing) word_idx <= last_word ? '0 : word_idx + 1'b1;
            if ((last_word && other_free) || resume) bank_sel <= !bank_sel;
            if (rel_ok) begin
                busy[rel_ptr] <= 1'b0;
                rel_ptr       <= !rel_ptr;
            end
            if (last_word) busy[bank_sel] <= 1'b1;
            frame_done <= last_word;
            err_tlast  <= accept && (s_axis_tlast != (beat_cnt == BCNT_W'(FRAME_BEATS - 1)));
            if (accept) beat_cnt <= (beat_cnt == BCNT_W'(FRAME_BEATS - 1)) ? '0 : beat_cnt + 1'b1;
        end
    end

    assign cur         = sh_data[SLICE_W-1:0];
    assign bram_en     = writing;
    assign bram_we     = writing ? 4'hF : 4'h0;
    assign bram_addr   = (bank_sel ? BANK_BYTES : 32'd0) + 32'({word_idx, 2'b00});
    assign bram_din_re = writing ? OUT_W'(sign_ext(64'(cur[SAMPLE_W-1:0]), SAMPLE_W, OUT_W)) : '0;
    assign bram_din_im = writing ? OUT_W'(sign_ext(64'(cur[SLICE_W-1:SAMPLE_W]), SAMPLE_W, OUT_W)) : '0;
    assign bram_rst    = rst;

endmodule

// File: tb/tb_fft_bram_pingpong_ctrl.sv
// Directed bench for fft_bram_pingpong_ctrl at default parameters.
module tb_fft_bram_pingpong_ctrl;
    localparam int NUM_CH      = 8;
    localparam int SAMPLE_W    = 24;
    localparam int OUT_W       = 32;
    localparam int FRAME_BEATS = 64;
    localparam int BEAT_W      = NUM_CH * 2 * SAMPLE_W;
    localparam int MAXW        = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [BEAT_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tready;
    logic              bank_release = 1'b0;
    logic [31:0]       bram_addr;
    logic [OUT_W-1:0]  bram_din_re, bram_din_im;
    logic [3:0]        bram_we;
    logic              bram_en, bram_rst, bank_sel, frame_done, err_tlast;

    fft_bram_pingpong_ctrl #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W), .FRAME_BEATS(FRAME_BEATS)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .bank_release(bank_release),
        .bram_addr(bram_addr), .bram_din_re(bram_din_re), .bram_din_im(bram_din_im),
        .bram_we(bram_we), .bram_en(bram_en), .bram_rst(bram_rst),
        .bank_sel(bank_sel), .frame_done(frame_done), .err_tlast(err_tlast)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0, wr_n = 0, fd_n = 0, err_n = 0;
    logic [31:0] wr_addr [MAXW];
    logic [31:0] wr_re   [MAXW];
    logic [31:0] wr_im   [MAXW];
    int          wr_cyc  [MAXW];

    // Write log sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (bram_en && wr_n < MAXW) begin
            wr_addr[wr_n] = bram_addr;
            wr_re[wr_n]   = bram_din_re;
            wr_im[wr_n]   = bram_din_im;
            wr_cyc[wr_n]  = cyc;
            wr_n++;
        end
        if (frame_done) fd_n++;
        if (err_tlast) err_n++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slice k of beat g: re = g*8+k (small positive), im = ~re (negative).
    function automatic logic [BEAT_W-1:0] beat_data(input int g);
        logic [BEAT_W-1:0] d;
        logic [23:0]       v;
        d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            v = 24'(g * 8 + k);
            d[k*48 +: 48] = {~v, v};
        end
        return d;
    endfunction

    task automatic check_range(input string tag, input int s, input int n,
                               input logic [31:0] addr0, input int w0);
        int          bad;
        logic [23:0] v;
        bad = 0;
        for (int j = 0; j < n; j++) begin
            v = 24'(w0 + j);
            if (wr_addr[s+j] !== addr0 + 32'(4 * j)) bad++;
            if (wr_re[s+j] !== {8'h00, v}) bad++;
            if (wr_im[s+j] !== {8'hFF, ~v}) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic send(input int n, input int g0, input bit bad_tlast);
        int i;
        int guard;
        bit took;
        i = 0;
        guard = 0;
        while (i < n && guard < 2000) begin
            s_axis_tdata  = beat_data(g0 + i);
            s_axis_tlast  = bad_tlast ? ((g0 + i) % 64 == 3) : ((g0 + i) % 64 == 63);
            s_axis_tvalid = 1'b1;
            @(negedge clk);
            took = s_axis_tready;
            @(posedge clk);
            #1;
            if (took) i++;
            guard++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk("send_accepted", i, n);
    endtask

    task automatic wait_writes(input int s, input int n);
        int guard;
        guard = 0;
        while (wr_n - s < n && guard < 1500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("write_wait", (wr_n - s >= n), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        bank_release = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_en", bram_en, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_bank", bank_sel, 0);
        chk("rst_bram_rst", bram_rst, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("tready_after_rst", s_axis_tready, 1);
    endtask

    initial begin
        int s, s2, fd0, e0, guard;
        logic [BEAT_W-1:0] d;

        // Single beat with extreme sample values
        do_reset();
        s = wr_n; fd0 = fd_n; e0 = err_n;
        d = beat_data(0);
        d[47:0] = {24'h800001, 24'h7FFFFF};
        s_axis_tdata = d;
        s_axis_tlast = 1'b0;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        chk("a_latency_en", bram_en, 1);
        chk("a_we", bram_we, 4'hF);
        chk("a_addr0", bram_addr, 32'h0);
        chk("a_im0", bram_din_im, 32'hFF800001);
        chk("a_re0", bram_din_re, 32'h007FFFFF);
        repeat (12) @(posedge clk);
        #1;
        chk("a_count", wr_n - s, 8);
        chk("a_addr7", wr_addr[s+7], 32'h1C);
        check_range("a_data", s + 1, 7, 32'h4, 1);
        chk("a_frame_done", fd_n - fd0, 0);
        chk("a_err", err_n - e0, 0);
        chk("a_idle_en", bram_en, 0);
        chk("a_idle_we", bram_we, 4'h0);

        // One full frame back to back, then the second bank
        do_reset();
        s = wr_n; fd0 = fd_n; e0 = err_n;
        send(64, 0, 1'b0);
        wait_writes(s, 512);
        repeat (3) @(posedge clk);
        #1;
        chk("b_count", wr_n - s, 512);
        chk("b_span", wr_cyc[s+511] - wr_cyc[s], 511);
        check_range("b_data", s, 512, 32'h0, 0);
        chk("b_frame_done", fd_n - fd0, 1);
        chk("b_bank_sel", bank_sel, 1);
        chk("b_err", err_n - e0, 0);

        s2 = wr_n;
        send(1, 64, 1'b0);
        chk("c_first_en", bram_en, 1);
        chk("c_first_addr", bram_addr, 32'h800);
        send(64, 65, 1'b0);
        wait_writes(s2, 512);
        repeat (20) @(posedge clk);
        #1;
        chk("c_count_stalled", wr_n - s2, 512);
        check_range("c_data", s2, 512, 32'h800, 512);
        chk("c_frame_done", fd_n - fd0, 2);
        chk("c_wait_tready", s_axis_tready, 0);
        chk("c_wait_en", bram_en, 0);
        chk("c_wait_bank", bank_sel, 1);

        bank_release = 1'b1;
        @(posedge clk);
        #1;
        bank_release = 1'b0;
        chk("r_en", bram_en, 1);
        chk("r_addr", bram_addr, 32'h0);
        chk("r_bank", bank_sel, 0);
        chk("r_re", bram_din_re, 32'h00000400);
        chk("r_im", bram_din_im, 32'hFFFFFBFF);
        repeat (12) @(posedge clk);
        #1;
        chk("r_count", wr_n - s2, 520);
        check_range("r_data", s2 + 512, 8, 32'h0, 1024);

        // tlast on beat 3 and missing on beat 63
        do_reset();
        s = wr_n; fd0 = fd_n; e0 = err_n;
        send(64, 0, 1'b1);
        wait_writes(s, 512);
        repeat (3) @(posedge clk);
        #1;
        chk("d_err_pulses", err_n - e0, 2);
        chk("d_count", wr_n - s, 512);
        check_range("d_data", s, 512, 32'h0, 0);
        chk("d_frame_done", fd_n - fd0, 1);

        // Reset in the middle of beat 10
        do_reset();
        send(11, 0, 1'b0);
        guard = 0;
        while (!(bram_en === 1'b1 && bram_addr === 32'h150) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("e_reached_slice4", (bram_en === 1'b1 && bram_addr === 32'h150), 1);
        rst = 1'b1;
        #1;
        chk("e_en", bram_en, 0);
        chk("e_we", bram_we, 0);
        chk("e_addr", bram_addr, 0);
        chk("e_re", bram_din_re, 0);
        chk("e_im", bram_din_im, 0);
        chk("e_tready", s_axis_tready, 0);
        chk("e_frame_done", frame_done, 0);
        chk("e_err", err_tlast, 0);
        chk("e_bram_rst", bram_rst, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        s = wr_n; e0 = err_n;
        send(1, 200, 1'b0);
        chk("e_restart_en", bram_en, 1);
        chk("e_restart_addr", bram_addr, 32'h0);
        chk("e_restart_re", bram_din_re, 32'h00000640);
        repeat (12) @(posedge clk);
        #1;
        chk("e_restart_count", wr_n - s, 8);
        chk("e_restart_err", err_n - e0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
